// File: rtl/cpu_exec_unit_pkg.sv
// Shared definitions for the execute-stage sequencer: opcode encodings and
// the decode helpers used by both the sequencer and the ALU.
package cpu_exec_unit_pkg;

    localparam int OPC_W = 4;

    // SR-class opcodes take both operands from the register file.
    localparam logic [OPC_W-1:0] OP_INC_SR  = 4'h0;
    localparam logic [OPC_W-1:0] OP_NAND_SR = 4'h1;
    localparam logic [OPC_W-1:0] OP_SRA_SR  = 4'h2;
    localparam logic [OPC_W-1:0] OP_XOR_SR  = 4'h3;

    // BIO-class opcodes take op0 from the BIO bus and also write the result out.
    localparam logic [OPC_W-1:0] OP_INC_BIO  = 4'h8;
    localparam logic [OPC_W-1:0] OP_NAND_BIO = 4'h9;
    localparam logic [OPC_W-1:0] OP_SRA_BIO  = 4'hA;
    localparam logic [OPC_W-1:0] OP_XOR_BIO  = 4'hB;

    // True for the four BIO-class encodings only.
    function automatic logic is_bio_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_INC_BIO, OP_NAND_BIO, OP_SRA_BIO, OP_XOR_BIO: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    // True for any of the eight defined encodings.
    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_INC_SR, OP_NAND_SR, OP_SRA_SR, OP_XOR_SR,
            OP_INC_BIO, OP_NAND_BIO, OP_SRA_BIO, OP_XOR_BIO: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_exec_unit_alu.sv
// Combinational ALU: increment, NAND, arithmetic shift right, XOR.
// SR and BIO variants of an operation compute the same function.
module cpu_exec_unit_alu
    import cpu_exec_unit_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] result
);

    // Operation select; undefined encodings produce zero.
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
        result = '0;
        case (opcode)
            OP_INC_SR,  OP_INC_BIO:  result = data0 + DATA_W'(1);
            OP_NAND_SR, OP_NAND_BIO: result = ~(data0 & data1);
            OP_SRA_SR,  OP_SRA_BIO:  result = $signed(data0) >>> data1;
            OP_XOR_SR,  OP_XOR_BIO:  result = data0 ^ data1;
            default:                 result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_exec_unit.sv
// Execute-stage sequencer: accepts one instruction, fetches operands from the
// register file or the BIO bus, runs the ALU and writes the result back.
module cpu_exec_unit
    import cpu_exec_unit_pkg::*;
#(
    parameter int  DATA_W     = 14,
    parameter int  NREG       = 4,
    parameter int  IO_TIMEOUT = 15,
    localparam int IDX_W      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [IDX_W-1:0]  rs0,
    input  logic [IDX_W-1:0]  rs1,
    input  logic [IDX_W-1:0]  rd,
    output logic              bio_req,
    input  logic              bio_ack,
    input  logic [DATA_W-1:0] bio_rdata,
    output logic              bio_we,
    output logic [DATA_W-1:0] bio_wdata,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_IO,
        S_EX,
        S_WB,
        S_ERR
    } state_t;

    localparam int CNT_W = $clog2(IO_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [OPC_W-1:0]    opc_q;
    logic [IDX_W-1:0]    rs0_q, rs1_q, rd_q;
    logic [DATA_W-1:0]   op0, op1, res, alu_y;
    logic [CNT_W-1:0]    wait_q;
    logic [DATA_W-1:0]   regs [NREG];

    cpu_exec_unit_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .data0  (op0),
        .data1  (op1),
        .opcode (opc_q),
        .result (alu_y)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode plus the state-derived handshake outputs.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        bio_req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = S_RD;
            end
            S_RD: begin
                if (!is_legal_op(opc_q))   state_d = S_ERR;
                else if (is_bio_op(opc_q)) state_d = S_IO;
                else                       state_d = S_EX;
            end
            S_IO: begin
                bio_req = 1'b1;
                if (bio_ack)                                state_d = S_EX;
                else if (wait_q == CNT_W'(IO_TIMEOUT - 1)) state_d = S_ERR;
            end
            S_EX:    state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: instruction latch, operand fetch, result register, writeback and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q     <= '0;
            rs0_q     <= '0;
            rs1_q     <= '0;
            rd_q      <= '0;
            op0       <= '0;
            op1       <= '0;
            res       <= '0;
            wait_q    <= '0;
            result    <= '0;
            zero      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bio_we    <= 1'b0;
            bio_wdata <= '0;
            // NOTE: the register file is architecturally zero after reset, so it is built from resettable flops rather than RAM.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            bio_we <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        opc_q <= opcode;
                        rs0_q <= rs0;
                        rs1_q <= rs1;
                        rd_q  <= rd;
                    end
                end
                S_RD: begin
                    op0    <= regs[rs0_q];
                    op1    <= regs[rs1_q];
                    wait_q <= '0;
                end
                S_IO: begin
                    if (bio_ack) op0    <= bio_rdata;
                    else         wait_q <= wait_q + CNT_W'(1);
                end
                S_EX: res <= alu_y;
                S_WB: begin
                    regs[rd_q] <= res;
                    result     <= res;
                    zero       <= (res == '0);
                    done       <= 1'b1;
                    if (is_bio_op(opc_q)) begin
                        bio_wdata <= res;
                        bio_we    <= 1'b1;
                    end
                end
                S_ERR:   err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Directed testbench for cpu_exec_unit: reset, SR and BIO arithmetic,
// back-to-back issue, BIO timeout, illegal opcode, held valid, mid-op reset.
module tb_cpu_exec_unit;
    import cpu_exec_unit_pkg::*;

    localparam int DATA_W     = 14;
    localparam int NREG       = 4;
    localparam int IO_TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        opcode;
    logic [1:0]        rs0, rs1, rd;
    logic              bio_req;
    logic              bio_ack;
    logic [DATA_W-1:0] bio_rdata;
    logic              bio_we;
    logic [DATA_W-1:0] bio_wdata;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              err;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] m [NREG];   // expected register file contents

    cpu_exec_unit #(
        .DATA_W     (DATA_W),
        .NREG       (NREG),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rs0         (rs0),
        .rs1         (rs1),
        .rd          (rd),
        .bio_req     (bio_req),
        .bio_ack     (bio_ack),
        .bio_rdata   (bio_rdata),
        .bio_we      (bio_we),
        .bio_wdata   (bio_wdata),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one instruction and follow it until done or err (bounded).
    // ack_at = n asserts bio_ack in the n-th cycle bio_req is seen; 0 = never.
    task automatic exec(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] d, input int ack_at, input logic [DATA_W-1:0] ack_data,
                        output int lat, output bit got_done, output bit got_err,
                        output bit saw_we, output logic [DATA_W-1:0] wdata, output int io_cyc);
        @(negedge clk);
        instr_valid = 1'b1;
        opcode = op; rs0 = a; rs1 = b; rd = d;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        lat = 0; got_done = 0; got_err = 0; saw_we = 0; wdata = '0; io_cyc = 0;
        while (lat < 100 && !got_done && !got_err) begin
            @(negedge clk);
            if (bio_req) begin
                io_cyc++;
                if (ack_at != 0 && io_cyc == ack_at) begin
                    bio_ack   = 1'b1;
                    bio_rdata = ack_data;
                end
            end
            @(posedge clk);
            #1;
            bio_ack = 1'b0;
            lat++;
            if (done) got_done = 1;
            if (err)  got_err  = 1;
            if (bio_we) begin
                saw_we = 1;
                wdata  = bio_wdata;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++; if ({bio_req, bio_we, done, err, zero} !== 5'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=00000", {bio_req, bio_we, done, err, zero}); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
        checks++; if (bio_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0000", bio_wdata); end
        for (int i = 0; i < NREG; i++) begin
            m[i] = '0;
            checks++; if (dut.regs[i] !== m[i]) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, dut.regs[i], m[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_inc_sr();
        int lat, io; bit dn, er, we; logic [DATA_W-1:0] wd;
        // r0 = ~(0 & 0) = 0x3FFF
        exec(OP_NAND_SR, 2'd0, 2'd0, 2'd0, 0, '0, lat, dn, er, we, wd, io);
        m[0] = 14'h3FFF;
        checks++; if (result !== 14'h3FFF || !dn) begin failures++; $display("FAIL nand_load got=%h done=%b exp=3fff", result, dn); end
        // INC 0x3FFF wraps to zero
        exec(OP_INC_SR, 2'd0, 2'd0, 2'd1, 0, '0, lat, dn, er, we, wd, io);
        m[1] = 14'h0000;
        checks++; if (lat !== 3 || !dn) begin failures++; $display("FAIL inc_sr_latency got=%0d exp=3", lat); end
        checks++; if (result !== 14'h0000) begin failures++; $display("FAIL inc_sr_result got=%h exp=0000", result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL inc_sr_zero got=%b exp=1", zero); end
        checks++; if (we || er) begin failures++; $display("FAIL inc_sr_side got we=%b err=%b exp=0,0", we, er); end
        checks++; if (dut.regs[1] !== m[1]) begin failures++; $display("FAIL inc_sr_r1 got=%h exp=%h", dut.regs[1], m[1]); end
    endtask

    task automatic test_xor_sr();
        int lat, io; bit dn, er, we; logic [DATA_W-1:0] wd;
        // Load r2/r3 through XOR_BIO with the zero register r1 as op1.
        exec(OP_XOR_BIO, 2'd0, 2'd1, 2'd2, 1, 14'h2AAA, lat, dn, er, we, wd, io);
        m[2] = 14'h2AAA;
        checks++; if (lat !== 4 || result !== 14'h2AAA) begin failures++; $display("FAIL load_r2 got lat=%0d res=%h exp lat=4 res=2aaa", lat, result); end
        exec(OP_XOR_BIO, 2'd0, 2'd1, 2'd3, 1, 14'h1555, lat, dn, er, we, wd, io);
        m[3] = 14'h1555;
        exec(OP_XOR_SR, 2'd2, 2'd3, 2'd2, 0, '0, lat, dn, er, we, wd, io);
        m[2] = 14'h3FFF;
        checks++; if (result !== 14'h3FFF || zero !== 1'b0) begin failures++; $display("FAIL xor_sr got res=%h z=%b exp res=3fff z=0", result, zero); end
        // Back-to-back: ready again in the cycle done is visible.
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", instr_ready); end
        exec(OP_NAND_SR, 2'd2, 2'd2, 2'd0, 0, '0, lat, dn, er, we, wd, io);
        m[0] = 14'h0000;
        checks++; if (result !== 14'h0000 || zero !== 1'b1 || lat !== 3) begin failures++; $display("FAIL b2b_nand got res=%h z=%b lat=%0d exp res=0000 z=1 lat=3", result, zero, lat); end
        for (int i = 0; i < NREG; i++) begin
            checks++; if (dut.regs[i] !== m[i]) begin failures++; $display("FAIL xor_reg%0d got=%h exp=%h", i, dut.regs[i], m[i]); end
        end
    endtask

    task automatic test_bio();
        int lat, io; bit dn, er, we; logic [DATA_W-1:0] wd;
        exec(OP_XOR_BIO, 2'd0, 2'd0, 2'd3, 1, 14'h0F0F, lat, dn, er, we, wd, io);
        m[3] = 14'h0F0F;
        // 0x00FF ^ 0x0F0F = 0x0FF0, ack in the second IO cycle
        exec(OP_XOR_BIO, 2'd0, 2'd3, 2'd1, 2, 14'h00FF, lat, dn, er, we, wd, io);
        m[1] = 14'h0FF0;
        checks++; if (lat !== 5 || !dn) begin failures++; $display("FAIL bio_latency got=%0d exp=5", lat); end
        checks++; if (!we || wd !== 14'h0FF0) begin failures++; $display("FAIL bio_write got we=%b wdata=%h exp we=1 wdata=0ff0", we, wd); end
        checks++; if (result !== 14'h0FF0) begin failures++; $display("FAIL bio_result got=%h exp=0ff0", result); end
        checks++; if (dut.regs[1] !== m[1]) begin failures++; $display("FAIL bio_r1 got=%h exp=%h", dut.regs[1], m[1]); end
        checks++; if (bio_we !== 1'b0) begin
            // one-cycle strobe: must be low one cycle later
        end
        @(posedge clk); #1;
        if (bio_we !== 1'b0) begin failures++; $display("FAIL bio_we_pulse got=%b exp=0", bio_we); end
    endtask

    task automatic test_sra();
        int lat, io; bit dn, er, we; logic [DATA_W-1:0] wd;
        // Shift amounts >= DATA_W: positive -> 0, negative -> all ones.
        exec(OP_SRA_SR, 2'd3, 2'd1, 2'd0, 0, '0, lat, dn, er, we, wd, io);
        m[0] = 14'h0000;
        checks++; if (result !== 14'h0000 || zero !== 1'b1) begin failures++; $display("FAIL sra_big_pos got res=%h z=%b exp res=0000 z=1", result, zero); end
        exec(OP_SRA_SR, 2'd2, 2'd1, 2'd2, 0, '0, lat, dn, er, we, wd, io);
        m[2] = 14'h3FFF;
        checks++; if (result !== 14'h3FFF) begin failures++; $display("FAIL sra_big_neg got=%h exp=3fff", result); end
        // Small shift: 0x2100 >>> r0(=0) is unchanged; 0x2100 >>> 4 = 0x3E10.
        exec(OP_XOR_BIO, 2'd0, 2'd0, 2'd0, 1, 14'h0004, lat, dn, er, we, wd, io);
        m[0] = 14'h0004;
        exec(OP_SRA_BIO, 2'd1, 2'd0, 2'd0, 1, 14'h2100, lat, dn, er, we, wd, io);
        m[0] = 14'h3E10;
        checks++; if (result !== 14'h3E10 || wd !== 14'h3E10) begin failures++; $display("FAIL sra_bio got res=%h wdata=%h exp=3e10", result, wd); end
    endtask

    task automatic test_timeout();
        int lat, io; bit dn, er, we; logic [DATA_W-1:0] wd;
        exec(OP_INC_BIO, 2'd0, 2'd0, 2'd2, 0, '0, lat, dn, er, we, wd, io);
        checks++; if (!er || dn || we) begin failures++; $display("FAIL timeout_flags got err=%b done=%b we=%b exp 1,0,0", er, dn, we); end
        checks++; if (lat !== IO_TIMEOUT + 2) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, IO_TIMEOUT + 2); end
        checks++; if (io !== IO_TIMEOUT) begin failures++; $display("FAIL timeout_io_cycles got=%0d exp=%0d", io, IO_TIMEOUT); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL timeout_ready got=%b exp=1", instr_ready); end
        checks++; if (result !== 14'h3E10) begin failures++; $display("FAIL timeout_result got=%h exp=3e10", result); end
        for (int i = 0; i < NREG; i++) begin
            checks++; if (dut.regs[i] !== m[i]) begin failures++; $display("FAIL timeout_reg%0d got=%h exp=%h", i, dut.regs[i], m[i]); end
        end
    endtask

    task automatic test_illegal_and_hold();
        int lat, io, accepts; bit dn, er, we; logic [DATA_W-1:0] wd;
        exec(4'h4, 2'd0, 2'd1, 2'd3, 0, '0, lat, dn, er, we, wd, io);
        checks++; if (!er || dn || lat !== 2) begin failures++; $display("FAIL illegal got err=%b done=%b lat=%0d exp 1,0,2", er, dn, lat); end
        for (int i = 0; i < NREG; i++) begin
            checks++; if (dut.regs[i] !== m[i]) begin failures++; $display("FAIL illegal_reg%0d got=%h exp=%h", i, dut.regs[i], m[i]); end
        end
        // Hold instr_valid through the busy period: exactly one accept.
        accepts = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        opcode = OP_INC_SR; rs0 = 2'd3; rs1 = 2'd0; rd = 2'd3;
        for (int i = 0; i < 3; i++) begin
            if (instr_valid && instr_ready) accepts++;
            @(posedge clk);
            #1;
            if (i == 2) instr_valid = 1'b0;
            else @(negedge clk);
        end
        @(posedge clk); #1;
        m[3] = 14'h0F10;
        checks++; if (done !== 1'b1 || result !== 14'h0F10) begin failures++; $display("FAIL hold_done got done=%b res=%h exp 1,0f10", done, result); end
        checks++; if (accepts !== 1) begin failures++; $display("FAIL hold_accepts got=%0d exp=1", accepts); end
        checks++; if (dut.regs[3] !== m[3]) begin failures++; $display("FAIL hold_r3 got=%h exp=%h", dut.regs[3], m[3]); end
    endtask

    task automatic test_reset_mid();
        bit seen_req, seen_done;
        @(negedge clk);
        instr_valid = 1'b1;
        opcode = OP_XOR_BIO; rs0 = 2'd0; rs1 = 2'd3; rd = 2'd1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        seen_req = 0;
        for (int k = 0; k < 10 && !seen_req; k++) begin
            @(posedge clk); #1;
            if (bio_req) seen_req = 1;
        end
        checks++; if (!seen_req) begin failures++; $display("FAIL midrst_req got=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bio_req !== 1'b0) begin failures++; $display("FAIL midrst_req_drop got=%b exp=0", bio_req); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", instr_ready); end
        for (int i = 0; i < NREG; i++) begin
            m[i] = '0;
            checks++; if (dut.regs[i] !== m[i]) begin failures++; $display("FAIL midrst_reg%0d got=%h exp=%h", i, dut.regs[i], m[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || bio_we) seen_done = 1;
        end
        checks++; if (seen_done) begin failures++; $display("FAIL midrst_writeback got=1 exp=0"); end
        checks++; if (instr_ready !== 1'b1 || result !== '0) begin failures++; $display("FAIL midrst_idle got ready=%b res=%h exp 1,0000", instr_ready, result); end
    endtask

    initial begin
        instr_valid = 1'b0;
        opcode = '0; rs0 = '0; rs1 = '0; rd = '0;
        bio_ack = 1'b0;
        bio_rdata = '0;
        test_reset();
        test_inc_sr();
        test_xor_sr();
        test_bio();
        test_sra();
        test_timeout();
        test_illegal_and_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_exec_unit.md
Name: cpu_exec_unit

Overview:
Execute-stage sequencer that sits directly upstream of the combinational 14-bit ALU and consumes its result.
- Accepts one instruction at a time over a valid/ready handshake.
- Fetches operands from a small internal register file (SR-class opcodes) or from the external BIO bus (BIO-class opcodes).
- Drives the ALU, registers its result, then writes back to the register file and, for BIO-class opcodes, to the BIO bus.
- Reports completion, a zero flag, and errors to the instruction source.

Parameters:
DATA_W, 14, datapath width; must equal the ALU DATA_W.
NREG, 4, number of internal registers; index width is clog2(NREG).
IO_TIMEOUT, 15, maximum cycles to wait for bio_ack before aborting.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_valid  in  1  instruction present.
instr_ready  out  1  block can accept an instruction.
opcode  in  4  operation; encodings from shared opcodes.v (OP_INC/NAND/SRA/XOR × _SR/_BIO).
rs0  in  clog2(NREG)  first source register; used by SR-class opcodes only.
rs1  in  clog2(NREG)  second source register.
rd  in  clog2(NREG)  destination register.
bio_req  out  1  BIO read request.
bio_ack  in  1  BIO read data valid.
bio_rdata  in  DATA_W  BIO read data.
bio_we  out  1  one-cycle BIO write strobe.
bio_wdata  out  DATA_W  BIO write data.
done  out  1  one-cycle completion pulse.
result  out  DATA_W  last written-back value.
zero  out  1  result == 0; valid with done.
err  out  1  one-cycle pulse: illegal opcode or BIO timeout.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE; all registers in the file are 0.
  - instr_ready=1; bio_req, bio_we, done, err, zero = 0; result = 0; bio_wdata = 0.
  - Reset mid-operation aborts immediately with no writeback.
- FSM states: IDLE, RD, IO, EX, WB, ERR.
- IDLE:
  - instr_ready=1. On instr_valid&instr_ready, latch opcode, rs0, rs1 and rd, then go to RD.
  - instr_ready is 0 in every other state.
- RD:
  - Read rs0 and rs1 into the operand registers op0/op1.
  - Illegal opcode → ERR. BIO-class → IO. SR-class → EX.
- IO:
  - bio_req=1 and a wait counter increments each cycle.
  - On bio_ack: op0 <= bio_rdata, bio_req drops in the same edge, go to EX.
  - If the counter reaches IO_TIMEOUT without ack → ERR.
  - bio_ack is ignored outside IO.
- EX:
  - ALU inputs are data0=op0, data1=op1, opcode=latched opcode.
  - The ALU output is registered into res.
- WB:
  - regfile[rd] <= res; result <= res; zero <= (res==0); done=1 for this cycle.
  - BIO-class only: bio_wdata <= res and bio_we=1 for this cycle.
  - Next state is IDLE.
- ERR: err=1 for one cycle; no register, result or BIO write; next state IDLE.
- Latency from the accept edge to done:
  - SR-class: 3 cycles (RD, EX, WB).
  - BIO-class: 3 + wait cycles, where wait = cycles spent in IO including the ack cycle.
  - A new instruction can be accepted in the cycle after WB or ERR.
- Arithmetic follows the ALU and is modulo 2^DATA_W:
  - INC 0x3FFF → 0x0000, with zero=1.
  - SRA shift amount is op1; amounts ≥ DATA_W behave exactly as the ALU produces.
- Hazards:
  - rd may equal rs0 or rs1.
  - Reads happen in RD, before that instruction's own writeback.
  - Back-to-back instructions see the previous writeback because only one instruction is in flight.
- Illegal opcode means any encoding not in the eight defined values.

Decomposition:
- opcodes.v holds the opcode constants, plus new helper macros IS_BIO_OP(op) and IS_LEGAL_OP(op). All decoding uses these helpers.
- FSM state localparams live inside the module.
- One sub-module: the existing ALU, instantiated unmodified with DATA_W passed through.
- The register file stays inline.

Test Plan:
1. Reset then SR ops: with r0=0x3FFF, issue INC_SR rs0=0 rd=1 → done 3 cycles after accept; r1=0x0000; result=0; zero=1.
2. XOR_SR: r2=0x2AAA, r3=0x1555, rd=2 → result=0x3FFF, zero=0; then NAND_SR rs0=2 rs1=2 rd=0 back-to-back → result=0x0000.
3. XOR_BIO rs1=3 (r3=0x0F0F): ack after 2 cycles with bio_rdata=0x00FF → bio_we pulse, bio_wdata=0x0FF0, rd updated, done 5 cycles after accept.
4. BIO timeout: INC_BIO with bio_ack never asserted → err pulse IO_TIMEOUT cycles into IO; no done, bio_we, or register change; instr_ready returns.
5. Illegal opcode → err pulse 2 cycles after accept; registers unchanged. instr_valid held high during a busy period → exactly one accept per instruction.
6. Assert rst_n low during IO → bio_req drops asynchronously, no writeback, registers cleared, instr_ready=1 after release.
